// File: rtl/selec_capture.sv
// Three-channel frame capture from a time-multiplexed sample stream.
// Frames are assembled in shadow registers and published atomically on the index-2 sample.
module selec_capture #(
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [1:0]        selec_mux,
  input  logic [DATA_W-1:0] sample_in,
  output logic [DATA_W-1:0] ch0,
  output logic [DATA_W-1:0] ch1,
  output logic [DATA_W-1:0] ch2,
  output logic              frame_valid,
  output logic              seq_error,
  output logic [7:0]        err_count,
  input  logic              clr_err
);

  typedef enum logic [1:0] {
    EXP0,
    EXP1,
    EXP2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] shadow0_q, shadow0_d;
  logic [DATA_W-1:0] shadow1_q, shadow1_d;
  logic [DATA_W-1:0] ch0_q, ch0_d;
  logic [DATA_W-1:0] ch1_q, ch1_d;
  logic [DATA_W-1:0] ch2_q, ch2_d;
  logic              frame_valid_q, frame_valid_d;
  logic              seq_error_q, seq_error_d;
  logic [7:0]        err_count_q, err_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= EXP0;
      shadow0_q     <= '0;
      shadow1_q     <= '0;
      ch0_q         <= '0;
      ch1_q         <= '0;
      ch2_q         <= '0;
      frame_valid_q <= 1'b0;
      seq_error_q   <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      shadow0_q     <= shadow0_d;
      shadow1_q     <= shadow1_d;
      ch0_q         <= ch0_d;
      ch1_q         <= ch1_d;
      ch2_q         <= ch2_d;
      frame_valid_q <= frame_valid_d;
      seq_error_q   <= seq_error_d;
      err_count_q   <= err_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shadow0_d     = shadow0_q;
    shadow1_d     = shadow1_q;
    ch0_d         = ch0_q;
    ch1_d         = ch1_q;
    ch2_d         = ch2_q;
    frame_valid_d = 1'b0;
    seq_error_d   = 1'b0;

    if (sample_valid) begin
      if (selec_mux == 2'd3) begin
        seq_error_d = 1'b1;
        state_d     = EXP0;
      end else begin
        case (state_q)
          EXP0: begin
            if (selec_mux == 2'd0) begin
              shadow0_d = sample_in;
              state_d   = EXP1;
            end else begin
              seq_error_d = 1'b1;
              state_d     = EXP0;
            end
          end
          EXP1: begin
            if (selec_mux == 2'd1) begin
              shadow1_d = sample_in;
              state_d   = EXP2;
            end else if (selec_mux == 2'd0) begin
              // An unexpected index 0 is treated as the start of a new frame.
              seq_error_d = 1'b1;
              shadow0_d   = sample_in;
              state_d     = EXP1;
            end else begin
              seq_error_d = 1'b1;
              state_d     = EXP0;
            end
          end
          EXP2: begin
            if (selec_mux == 2'd2) begin
              ch0_d         = shadow0_q;
              ch1_d         = shadow1_q;
              ch2_d         = sample_in;
              frame_valid_d = 1'b1;
              state_d       = EXP0;
            end else if (selec_mux == 2'd0) begin
              seq_error_d = 1'b1;
              shadow0_d   = sample_in;
              state_d     = EXP1;
            end else begin
              seq_error_d = 1'b1;
              state_d     = EXP0;
            end
          end
          default: state_d = EXP0;
        endcase
      end
    end

    // Clear wins over the old count, but an error in the same cycle still counts.
    if (clr_err) begin
      err_count_d = seq_error_d ? 8'd1 : 8'd0;
    end else if (seq_error_d && (err_count_q != '1)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  assign ch0         = ch0_q;
  assign ch1         = ch1_q;
  assign ch2         = ch2_q;
  assign frame_valid = frame_valid_q;
  assign seq_error   = seq_error_q;
  assign err_count   = err_count_q;

endmodule

// File: doc/selec_capture.md
SELEC_CAPTURE -- requirements
Module: selec_capture

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, meaning the sample width in bits (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port sample_valid, input, 1 bit: qualifies selec_mux and sample_in for the current cycle.
REQ-005 The block SHALL have port selec_mux, input, 2 bits: channel index of the sample, with legal values 0, 1 and 2.
REQ-006 The block SHALL have port sample_in, input, DATA_W bits: sample value for the indexed channel.
REQ-007 The block SHALL have ports ch0, ch1 and ch2, each output, DATA_W bits: last complete frame, held between frames.
REQ-008 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse when ch0..ch2 update.
REQ-009 The block SHALL have port seq_error, output, 1 bit: one-cycle pulse on each rejected sample.
REQ-010 The block SHALL have port err_count, output, 8 bits: saturating count of rejected samples.
REQ-011 The block SHALL have port clr_err, input, 1 bit: zeroes err_count.

Function
REQ-012 The block SHALL implement a state machine with the states EXP0, EXP1 and EXP2, meaning the next expected index is 0, 1 or 2.
REQ-013 Cycles with sample_valid=0 SHALL change no state, no shadow register and no output, except that frame_valid and seq_error deassert.
REQ-014 In state EXPn, an accepted sample (sample_valid=1, selec_mux=n) SHALL be written to shadow register n, and the state SHALL advance: EXP0 to EXP1, EXP1 to EXP2, EXP2 to EXP0.
REQ-015 An accepted sample in EXP2 SHALL, at the same edge, load ch0 and ch1 from their shadow registers and ch2 from sample_in, and SHALL drive frame_valid=1 for the following cycle only; latency from the index-2 sample to the outputs SHALL be 1 clock.
REQ-016 When selec_mux=0 while the state is EXP1 or EXP2, the block SHALL pulse seq_error, discard the partial frame, store sample_in in shadow 0 and go to EXP1 (resynchronise).
REQ-017 Any other mismatched index (1 or 2 while not expected) SHALL pulse seq_error, discard the partial frame and go to EXP0.
REQ-018 selec_mux=3 with sample_valid=1 SHALL pulse seq_error and go to EXP0 from any state; no shadow register SHALL be written.
REQ-019 An index-0 sample in EXP0 SHALL be accepted normally (no error) and SHALL overwrite shadow 0.
REQ-020 err_count SHALL increment by 1 for each seq_error pulse and SHALL saturate at 255.
REQ-021 When clr_err=1 and an error occur in the same cycle, err_count SHALL become 1; when clr_err=1 alone, err_count SHALL become 0.
REQ-022 ch0..ch2 SHALL never update on a partial or aborted frame.
REQ-023 frame_valid and seq_error SHALL never both be 1 in the same cycle.
REQ-024 An output pulse SHALL last exactly one cycle even when valid samples arrive back-to-back.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL set state to EXP0, shadows to 0, ch0..ch2 to 0, frame_valid to 0, seq_error to 0 and err_count to 0.
REQ-026 rst SHALL take priority over sample_valid and clr_err.
REQ-027 A reset asserted mid-frame SHALL discard the partial frame, and the next frame SHALL start at index 0.
REQ-028 The block SHALL behave identically when rst is held for multiple cycles.

Verification
REQ-029 The bench SHALL cover this scenario: after reset, drive valid samples (0,0x111), (1,0x222), (2,0x333) -> ch0=0x111, ch1=0x222, ch2=0x333, with one frame_valid pulse 1 cycle after the index-2 sample and err_count=0.
REQ-030 The bench SHALL cover this scenario: drive (0,0xA), (2,0xB) -> seq_error pulse, state EXP0, ch outputs unchanged, err_count=1; then (0,1), (1,2), (2,3) -> frame 1/2/3.
REQ-031 The bench SHALL cover this scenario: drive (0,5), (1,6), (0,7), (1,8), (2,9) -> exactly one seq_error pulse (on the second index 0) and a frame of 7/8/9.
REQ-032 The bench SHALL cover this scenario: drive selec_mux=3 with valid high in each state -> seq_error each time, no shadow write, return to EXP0.
REQ-033 The bench SHALL cover this scenario: drive 300 consecutive errors -> err_count=255; then clr_err=1 together with an error -> err_count=1.
REQ-034 The bench SHALL cover this scenario: assert rst after indices 0 and 1 -> all outputs 0; then (1,x) -> seq_error; then (0,1), (1,2), (2,3) -> frame 1/2/3.
